// File: rtl/vga_layer_compositor.sv
// VGA timing generator with an N-slot rectangle compositor, double-buffered object table,
// three-stage pixel pipeline (hit test, colour select, dimming) and aligned syncs.
module vga_layer_compositor #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int N_OBJ    = 8,
  parameter int COORD_W  = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     obj_wr_en,
  input  logic [$clog2(N_OBJ)-1:0] obj_wr_idx,
  input  logic [COORD_W-1:0]       obj_wr_x,
  input  logic [COORD_W-1:0]       obj_wr_y,
  input  logic [COORD_W-1:0]       obj_wr_w,
  input  logic [COORD_W-1:0]       obj_wr_h,
  input  logic [11:0]              obj_wr_color,
  input  logic                     obj_wr_vis,
  output logic                     obj_wr_ready,
  input  logic [11:0]              bg_color,
  input  logic [3:0]               dim_level,
  output logic                     HS,
  output logic                     VS,
  output logic [3:0]               vgaRed,
  output logic [3:0]               vgaGreen,
  output logic [3:0]               vgaBlue,
  output logic                     frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] w;
    logic [COORD_W-1:0] h;
    logic [11:0]        color;
    logic               vis;
  } obj_t;

  logic [DIV_W-1:0]   div_cnt;
  logic [COORD_W-1:0] hcount;
  logic [COORD_W-1:0] vcount;
  logic               pix_en;
  logic               commit;
  logic               hs_raw;
  logic               vs_raw;
  logic               active_raw;

  obj_t shadow [N_OBJ];
  obj_t live   [N_OBJ];

  logic [N_OBJ-1:0] hit_nxt;
  logic [N_OBJ-1:0] hit1;
  logic             act1;
  logic             hs1, vs1;
  logic [11:0]      col_nxt;
  logic [11:0]      col2;
  logic             hs2, vs2;
  logic             hs3, vs3;

  assign pix_en       = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign commit       = pix_en && (hcount == '0) && (vcount == COORD_W'(V_ACTIVE));
  assign obj_wr_ready = !commit;
  assign frame_start  = pix_en && (hcount == '0) && (vcount == '0);

  assign hs_raw = (hcount >= COORD_W'(H_ACTIVE + H_FP)) &&
                  (hcount <  COORD_W'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_raw = (vcount >= COORD_W'(V_ACTIVE + V_FP)) &&
                  (vcount <  COORD_W'(V_ACTIVE + V_FP + V_SYNC));
  assign active_raw = (hcount < COORD_W'(H_ACTIVE)) && (vcount < COORD_W'(V_ACTIVE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      hcount  <= '0;
      vcount  <= '0;
    end else begin
      div_cnt <= pix_en ? '0 : div_cnt + 1'b1;
      if (pix_en) begin
        if (hcount == COORD_W'(H_TOTAL - 1)) begin
          hcount <= '0;
          vcount <= (vcount == COORD_W'(V_TOTAL - 1)) ? '0 : vcount + 1'b1;
        end else begin
          hcount <= hcount + 1'b1;
        end
      end
    end
  end

  // Writes never land in the commit cycle, so the copy always sees a stable shadow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_OBJ; i++) begin
        shadow[i] <= '0;
        live[i]   <= '0;
      end
    end else begin
      if (obj_wr_en && obj_wr_ready)
        shadow[obj_wr_idx] <= '{x: obj_wr_x, y: obj_wr_y, w: obj_wr_w, h: obj_wr_h,
                                color: obj_wr_color, vis: obj_wr_vis};
      if (commit)
        live <= shadow;
    end
  end

  // Extents are summed one bit wider so a rectangle running past the coordinate range never wraps.
  always_comb begin
    hit_nxt = '0;
    for (int i = 0; i < N_OBJ; i++) begin
      hit_nxt[i] = live[i].vis &&
                   (hcount >= live[i].x) &&
                   ({1'b0, hcount} < ({1'b0, live[i].x} + {1'b0, live[i].w})) &&
                   (vcount >= live[i].y) &&
                   ({1'b0, vcount} < ({1'b0, live[i].y} + {1'b0, live[i].h}));
    end
  end

  always_comb begin
    col_nxt = bg_color;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (hit1[i])
        col_nxt = live[i].color;
    end
    if (!act1)
      col_nxt = '0;
  end

  function automatic logic [3:0] dim_ch(input logic [3:0] c, input logic [3:0] d);
    logic [4:0] mul;
    mul = 5'd16 - {1'b0, d};
    return 4'(({4'b0, c} * {3'b0, mul}) >> 4);
  endfunction

  // Sync pipeline carries "in sync pulse" flags so every pipeline register resets to 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit1     <= '0;
      act1     <= 1'b0;
      hs1      <= 1'b0;
      vs1      <= 1'b0;
      col2     <= '0;
      hs2      <= 1'b0;
      vs2      <= 1'b0;
      hs3      <= 1'b0;
      vs3      <= 1'b0;
      vgaRed   <= '0;
      vgaGreen <= '0;
      vgaBlue  <= '0;
    end else if (pix_en) begin
      hit1     <= hit_nxt;
      act1     <= active_raw;
      hs1      <= hs_raw;
      vs1      <= vs_raw;
      col2     <= col_nxt;
      hs2      <= hs1;
      vs2      <= vs1;
      hs3      <= hs2;
      vs3      <= vs2;
      vgaRed   <= dim_ch(col2[11:8], dim_level);
      vgaGreen <= dim_ch(col2[7:4],  dim_level);
      vgaBlue  <= dim_ch(col2[3:0],  dim_level);
    end
  end

  assign HS = !hs3;
  assign VS = !vs3;

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Directed bench for vga_layer_compositor on a reduced raster; a pixel-level model pushes
// expected outputs into a scoreboard queue that is popped as each pipelined pixel emerges.
module tb_vga_layer_compositor;

  localparam int CD    = 4;
  localparam int HA    = 32;
  localparam int HF    = 2;
  localparam int HSY   = 4;
  localparam int HB    = 2;
  localparam int VA    = 12;
  localparam int VF    = 1;
  localparam int VSY   = 2;
  localparam int VB    = 1;
  localparam int NO    = 8;
  localparam int CW    = 11;
  localparam int HT    = HA + HF + HSY + HB;
  localparam int VT    = VA + VF + VSY + VB;
  localparam int FRAME = HT * VT * CD;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          obj_wr_en = 1'b0;
  logic [2:0]    obj_wr_idx = '0;
  logic [CW-1:0] obj_wr_x = '0, obj_wr_y = '0, obj_wr_w = '0, obj_wr_h = '0;
  logic [11:0]   obj_wr_color = '0;
  logic          obj_wr_vis = 1'b0;
  logic          obj_wr_ready;
  logic [11:0]   bg_color = 12'hF00;
  logic [3:0]    dim_level = 4'd0;
  logic          HS, VS, frame_start;
  logic [3:0]    vgaRed, vgaGreen, vgaBlue;

  int checks = 0;
  int errors = 0;

  vga_layer_compositor #(
    .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB), .N_OBJ(NO), .COORD_W(CW)
  ) dut (
    .clk(clk), .rst(rst_n),
    .obj_wr_en(obj_wr_en), .obj_wr_idx(obj_wr_idx),
    .obj_wr_x(obj_wr_x), .obj_wr_y(obj_wr_y), .obj_wr_w(obj_wr_w), .obj_wr_h(obj_wr_h),
    .obj_wr_color(obj_wr_color), .obj_wr_vis(obj_wr_vis), .obj_wr_ready(obj_wr_ready),
    .bg_color(bg_color), .dim_level(dim_level),
    .HS(HS), .VS(VS), .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int x; int y; int w; int h; logic [11:0] c; bit v; } mobj_t;
  typedef struct { bit hs; bit vs; bit act; int hit; logic [11:0] col; int x; int y; } exp_t;

  mobj_t sh_tab [NO];
  mobj_t lv_tab [NO];
  exp_t  q [$];
  exp_t  pend;
  int    mdiv = 0, mh = 0, mv = 0;
  int    tick_dim = 0;
  bit    tick_seen = 0;

  int          spot_set = 0;
  int          spot_hits = 0;
  int          spot_x [8] = '{14, 15, 22, 20, 31, 30, 5, 32};
  int          spot_y [8] = '{3, 5, 7, 8, 9, 10, 1, 9};
  logic [11:0] spot_c [8] = '{12'h0F0, 12'h0F0, 12'h00F, 12'hF00, 12'h888, 12'h888, 12'hF00, 12'h000};
  int          dim8_cnt = 0, dim15_cnt = 0;

  function automatic exp_t reset_entry();
    exp_t e;
    e.hs = 1; e.vs = 1; e.act = 0; e.hit = -1; e.col = '0; e.x = -1; e.y = -1;
    return e;
  endfunction

  function automatic exp_t px(int h, int v);
    exp_t e;
    e.x = h; e.y = v; e.col = '0; e.hit = -1;
    e.hs  = !(h >= HA + HF && h < HA + HF + HSY);
    e.vs  = !(v >= VA + VF && v < VA + VF + VSY);
    e.act = (h < HA) && (v < VA);
    if (e.act)
      for (int i = NO - 1; i >= 0; i--)
        if (lv_tab[i].v && h >= lv_tab[i].x && h < lv_tab[i].x + lv_tab[i].w &&
            v >= lv_tab[i].y && v < lv_tab[i].y + lv_tab[i].h)
          e.hit = i;
    return e;
  endfunction

  function automatic logic [11:0] dim12(logic [11:0] c, int d);
    int r, g, b;
    r = (int'(c[11:8]) * (16 - d)) / 16;
    g = (int'(c[7:4])  * (16 - d)) / 16;
    b = (int'(c[3:0])  * (16 - d)) / 16;
    return {4'(r), 4'(g), 4'(b)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit   pix, cmt;
    exp_t r;
    if (!rst_n) begin
      mdiv = 0; mh = 0; mv = 0; tick_seen = 0;
      for (int i = 0; i < NO; i++) begin
        sh_tab[i] = '{0, 0, 0, 0, 12'h000, 1'b0};
        lv_tab[i] = '{0, 0, 0, 0, 12'h000, 1'b0};
      end
      q.delete();
      q.push_back(reset_entry());
      pend = reset_entry();
    end else begin
      pix = (mdiv == CD - 1);
      cmt = pix && mh == 0 && mv == VA;
      if (pix) begin
        r = pend;
        if (!r.act)        r.col = '0;
        else if (r.hit < 0) r.col = bg_color;
        else               r.col = lv_tab[r.hit].c;
        q.push_back(r);
        pend = px(mh, mv);
        tick_dim = int'(dim_level);
        tick_seen = 1;
        if (mh == HT - 1) begin
          mh = 0;
          mv = (mv == VT - 1) ? 0 : mv + 1;
        end else begin
          mh = mh + 1;
        end
      end
      if (cmt)
        lv_tab = sh_tab;
      else if (obj_wr_en)
        sh_tab[obj_wr_idx] = '{int'(obj_wr_x), int'(obj_wr_y), int'(obj_wr_w), int'(obj_wr_h),
                               obj_wr_color, obj_wr_vis};
      mdiv = pix ? 0 : mdiv + 1;
    end
  end

  always @(negedge clk) begin
    exp_t        e;
    logic [11:0] exp_rgb, obs_rgb;
    chk("wr_ready", 32'(obj_wr_ready), 32'(!(mdiv == CD - 1 && mh == 0 && mv == VA)));
    chk("frame_start", 32'(frame_start), 32'(mdiv == CD - 1 && mh == 0 && mv == 0));
    if (tick_seen) begin
      tick_seen = 0;
      chk("queue_nonempty", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        exp_rgb = dim12(e.col, tick_dim);
        obs_rgb = {vgaRed, vgaGreen, vgaBlue};
        chk($sformatf("hs@%0d,%0d", e.x, e.y), 32'(HS), 32'(e.hs));
        chk($sformatf("vs@%0d,%0d", e.x, e.y), 32'(VS), 32'(e.vs));
        chk($sformatf("rgb@%0d,%0d", e.x, e.y), 32'(obs_rgb), 32'(exp_rgb));
        for (int s = 0; s < 4; s++) begin
          int k;
          k = (spot_set - 1) * 4 + s;
          if (spot_set != 0 && e.x == spot_x[k] && e.y == spot_y[k]) begin
            spot_hits++;
            chk($sformatf("spot@%0d,%0d", e.x, e.y), 32'(obs_rgb), 32'(spot_c[k]));
          end
        end
        if (tick_dim == 8 && e.col == 12'hFFF) begin
          dim8_cnt++;
          chk("dim8_white", 32'(obs_rgb), 32'h777);
        end
        if (tick_dim == 15) begin
          dim15_cnt++;
          chk("dim15_black", 32'(obs_rgb), 32'h000);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr(input int idx, input int x, input int y, input int w, input int h,
                    input logic [11:0] c, input bit vis);
    @(negedge clk);
    obj_wr_idx = 3'(idx); obj_wr_x = CW'(x); obj_wr_y = CW'(y);
    obj_wr_w = CW'(w); obj_wr_h = CW'(h); obj_wr_color = c; obj_wr_vis = vis;
    obj_wr_en = 1'b1;
    for (int n = 0; n < 4 && !obj_wr_ready; n++) @(negedge clk);
    @(negedge clk);
    obj_wr_en = 1'b0;
  endtask

  task automatic wait_until(input string tag, input int h, input int v, input bit any_h);
    int n;
    n = 0;
    while (!(mv == v && (any_h || mh == h)) && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    chk({"reach_", tag}, 32'(n < 2 * FRAME), 32'd1);
  endtask

  task automatic wait_frame_start();
    int n;
    n = 0;
    @(negedge clk);
    while (!(mdiv == CD - 1 && mh == 0 && mv == 0) && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    chk("reach_frame_start", 32'(n < 2 * FRAME), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_hs"}, 32'(HS), 32'd1);
    chk({tag, "_vs"}, 32'(VS), 32'd1);
    chk({tag, "_rgb"}, 32'({vgaRed, vgaGreen, vgaBlue}), 32'h000);
    chk({tag, "_ready"}, 32'(obj_wr_ready), 32'd1);
    chk({tag, "_fs"}, 32'(frame_start), 32'd0);
  endtask

  task automatic fs_latency(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 20);
    // release lands mid-cycle, so the pix_en cycle is the third full negedge after it
    chk(tag, 32'(n), 32'(CD - 1));
  endtask

  // width in clks of the low phase of HS (sel=0) or VS (sel=1)
  task automatic low_width(input bit sel, output int width);
    int n;
    n = 0;
    while (!(sel ? VS : HS) && n < 2 * FRAME) begin @(negedge clk); n++; end
    while ((sel ? VS : HS) && n < 2 * FRAME) begin @(negedge clk); n++; end
    width = 0;
    while (!(sel ? VS : HS) && n < 2 * FRAME) begin @(negedge clk); n++; width++; end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int w, per, lows;

    #2;
    chk_reset_outputs("reset_state");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    fs_latency("fs_latency_por");

    low_width(1'b0, w);
    chk("hs_low_width", 32'(w), 32'(HSY * CD));
    per = w;
    while (HS && per < 2 * FRAME) begin @(negedge clk); per++; end
    chk("hs_period", 32'(per), 32'(HT * CD));
    low_width(1'b1, w);
    chk("vs_low_width", 32'(w), 32'(VSY * HT * CD));

    // two overlapping rectangles, lower slot wins
    wait_until("act1", 0, 1, 1'b1);
    wr(0, 10, 3, 10, 5, 12'h0F0, 1'b1);
    wr(1, 15, 3, 10, 5, 12'h00F, 1'b1);
    wait_frame_start();
    spot_hits = 0; spot_set = 1;
    repeat (FRAME - 2 * HT) @(negedge clk);
    spot_set = 0;
    chk("spot1_seen", 32'(spot_hits), 32'd4);

    // rewrite during active lines: current frame keeps old object
    wait_until("act2", 0, 2, 1'b1);
    wr(0, 2, 3, 10, 5, 12'hFF0, 1'b1);
    wait_frame_start();
    wait_frame_start();

    // hold a write across the commit cycle; the commit-cycle data must be dropped
    wait_until("act3", 0, 1, 1'b1);
    @(negedge clk);
    obj_wr_idx = 3'd2; obj_wr_x = 0; obj_wr_y = 0; obj_wr_w = 3; obj_wr_h = 2;
    obj_wr_color = 12'h0FF; obj_wr_vis = 1'b1; obj_wr_en = 1'b1;
    w = 0;
    while (obj_wr_ready && w < 2 * FRAME) begin @(negedge clk); w++; end
    chk("ready_low_seen", 32'(obj_wr_ready), 32'd0);
    obj_wr_color = 12'hF0F;
    @(negedge clk);
    chk("ready_after_commit", 32'(obj_wr_ready), 32'd1);
    obj_wr_en = 1'b0;
    lows = 0;
    repeat (FRAME) begin
      @(negedge clk);
      if (!obj_wr_ready) lows++;
    end
    chk("ready_low_per_frame", 32'(lows), 32'd1);
    wait_frame_start();

    // right-edge clipping and zero-width slot
    wait_until("act4", 0, 1, 1'b1);
    wr(3, 30, 9, 100, 2, 12'h888, 1'b1);
    wr(4, 5, 0, 0, 12, 12'h444, 1'b1);
    wait_frame_start();
    spot_hits = 0; spot_set = 2;
    repeat (FRAME - 2 * HT) @(negedge clk);
    spot_set = 0;
    chk("spot2_seen", 32'(spot_hits), 32'd4);

    // dimming
    bg_color = 12'hFFF;
    dim_level = 4'd8;
    wait_frame_start();
    repeat (FRAME) @(negedge clk);
    dim_level = 4'd15;
    repeat (FRAME / 2) @(negedge clk);
    dim_level = 4'd0;
    chk("dim8_seen", 32'(dim8_cnt > 0), 32'd1);
    chk("dim15_seen", 32'(dim15_cnt > 0), 32'd1);

    // mid-line reset discards an uncommitted write
    wait_until("act5", 0, 1, 1'b1);
    wr(5, 0, 0, 32, 12, 12'h0F0, 1'b1);
    wait_until("midline", 10, 2, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("reset_mid");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    fs_latency("fs_latency_mid");
    bg_color = 12'h00F;
    repeat (2 * FRAME + 100) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
